// File: rtl/mod_pll_pkg.sv
// Shared types and width helpers for the PLL supervisor.
package mod_pll_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_sup_state_t;

  localparam int unsigned SUP_MIN_W = 1;

  function automatic int unsigned sup_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold counts 0..n-1.
  function automatic int unsigned sup_bits_for(input int unsigned n);
    return (n <= 2) ? SUP_MIN_W : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level.
module mod_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE", altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/mod_pll_supervisor.sv
// PLL start-up sequencer and lock qualifier driving the PLL reset and the downstream reset.
// Optional RUN-state loss filter: define PLL_SUPERVISOR_LOSS_FILTER_EN.
module mod_pll_supervisor
  import mod_pll_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned LOSS_FILTER    = 8,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked_i,
  output logic             pll_rst_o,
  output logic             sys_rst_o,
  output logic             ready_o,
  output logic [CNT_W-1:0] relock_cnt_o
);

  localparam bit CFG_OK = (SYNC_STAGES >= 2) && (PLL_RST_CYCLES >= 1) &&
                          (LOCK_TIMEOUT >= 1) && (LOCK_STABLE >= 1) &&
                          (LOSS_FILTER >= 1) && (CNT_W >= 1);

  if (!CFG_OK) begin : g_cfg_check
    $error("mod_pll_supervisor: illegal parameter combination");
  end

  localparam int unsigned TMR_W =
    sup_bits_for(sup_max3(LOCK_TIMEOUT, LOCK_STABLE, PLL_RST_CYCLES));

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(LOCK_STABLE - 1);

  pll_sup_state_t   r_state;
  pll_sup_state_t   w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [CNT_W-1:0] r_relock_cnt;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             w_locked_s;
  logic             w_loss;
  logic             w_relock_inc;

  mod_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_locked (
    .i_clk (refclk),
    .i_d   (locked_i),
    .o_q   (w_locked_s)
  );

`ifdef PLL_SUPERVISOR_LOSS_FILTER_EN
  localparam int unsigned FLT_W = sup_bits_for(LOSS_FILTER);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOSS_FILTER - 1);

  logic [FLT_W-1:0] r_flt;

  // Counts consecutive low samples in RUN; any high sample or leaving RUN clears it.
  always_ff @(posedge refclk) begin
    if (rst || (r_state != RUN) || w_locked_s || w_loss) begin
      r_flt <= '0;
    end else begin
      r_flt <= r_flt + 1'b1;
    end
  end

  assign w_loss = !w_locked_s && (r_flt == FLT_LAST);
`else
  assign w_loss = !w_locked_s;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer + 1'b1;
    w_relock_inc = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_timer == RST_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_timer_nxt = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock is checked first so it wins over a coincident timeout.
        if (w_locked_s) begin
          w_state_nxt = STABLE;
          w_timer_nxt = '0;
        end else if (r_timer == TO_LAST) begin
          w_state_nxt = PLL_RST;
          w_timer_nxt = '0;
        end
      end
      STABLE: begin
        if (!w_locked_s) begin
          w_state_nxt = WAIT_LOCK;
          w_timer_nxt = '0;
        end else if (r_timer == STB_LAST) begin
          w_state_nxt = RUN;
          w_timer_nxt = '0;
        end
      end
      RUN: begin
        w_timer_nxt = '0;
        if (w_loss) begin
          w_state_nxt  = PLL_RST;
          w_relock_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = PLL_RST;
        w_timer_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as the FSM.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state      <= PLL_RST;
      r_timer      <= '0;
      r_pll_rst    <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_ready      <= 1'b0;
      r_relock_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_pll_rst <= (w_state_nxt == PLL_RST);
      r_sys_rst <= (w_state_nxt != RUN);
      r_ready   <= (w_state_nxt == RUN);
      if (w_relock_inc && (r_relock_cnt != '1)) begin
        r_relock_cnt <= r_relock_cnt + 1'b1;
      end
    end
  end

  assign pll_rst_o    = r_pll_rst;
  assign sys_rst_o    = r_sys_rst;
  assign ready_o      = r_ready;
  assign relock_cnt_o = r_relock_cnt;

endmodule

// File: tb/tb_mod_pll_supervisor.sv
// Scoreboard bench for mod_pll_supervisor: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_mod_pll_supervisor;

  logic       clk;
  logic       rst;
  logic       locked_i;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       ready_o;
  logic [7:0] relock_cnt_o;

  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  int unsigned  q_cyc[$];
  string        q_tag[$];
  logic [10:0]  q_exp[$];
  logic [10:0]  m_act;
  logic [10:0]  m_exp;

  mod_pll_supervisor #(
    .SYNC_STAGES    (2),
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .LOCK_STABLE    (8),
    .LOSS_FILTER    (3),
    .CNT_W          (8)
  ) dut (
    .refclk       (clk),
    .rst          (rst),
    .locked_i     (locked_i),
    .pll_rst_o    (pll_rst_o),
    .sys_rst_o    (sys_rst_o),
    .ready_o      (ready_o),
    .relock_cnt_o (relock_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // cyc counts completed rising edges; expectations are tagged with the edge after which they hold.
  task automatic expect_at(input int unsigned c, input string tag,
                           input logic pr, input logic sr, input logic rd,
                           input int unsigned cnt);
    logic [7:0] c8;
    c8 = 8'(cnt);
    q_cyc.push_back(c);
    q_tag.push_back(tag);
    q_exp.push_back({pr, sr, rd, c8});
  endtask

  // Loss taken at edge l with locked_s high from l+1 on: 4 reset, 1 wait, 8 stable.
  task automatic expect_recover(input int unsigned l, input int unsigned cnt);
    expect_at(l,      "loss_edge",  1'b1, 1'b1, 1'b0, cnt);
    expect_at(l + 3,  "relock_rst", 1'b1, 1'b1, 1'b0, cnt);
    expect_at(l + 4,  "relock_wait",1'b0, 1'b1, 1'b0, cnt);
    expect_at(l + 12, "relock_stb", 1'b0, 1'b1, 1'b0, cnt);
    expect_at(l + 13, "relock_run", 1'b0, 1'b0, 1'b1, cnt);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int unsigned n);
    while (cyc < n) tick(1);
  endtask

  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      m_act  = {pll_rst_o, sys_rst_o, ready_o, relock_cnt_o};
      m_exp  = q_exp[0];
      checks = checks + 1;
      if (q_cyc[0] != cyc) begin
        errors = errors + 1;
        $display("FAIL %s stale expectation for cycle %0d seen at cycle %0d", q_tag[0], q_cyc[0], cyc);
      end else if (m_act !== m_exp) begin
        errors = errors + 1;
        $display("FAIL %s cyc=%0d got pll_rst=%b sys_rst=%b ready=%b cnt=%0d want pll_rst=%b sys_rst=%b ready=%b cnt=%0d",
                 q_tag[0], cyc, m_act[10], m_act[9], m_act[8], m_act[7:0],
                 m_exp[10], m_exp[9], m_exp[8], m_exp[7:0]);
      end
      void'(q_cyc.pop_front());
      void'(q_tag.pop_front());
      void'(q_exp.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r, f, g, h, t, w, s, c;
    rst      = 1'b1;
    locked_i = 1'b0;

    // Reset for 3 cycles, then PLL reset pulse and first lock.
    expect_at(1, "reset_state", 1'b1, 1'b1, 1'b0, 0);
    tick(3);
    rst = 1'b0;
    r   = cyc;
    expect_at(r + 3, "pll_rst_last", 1'b1, 1'b1, 1'b0, 0);
    expect_at(r + 4, "pll_rst_fall", 1'b0, 1'b1, 1'b0, 0);
    wait_to(r + 14);
    locked_i = 1'b1;
    f = cyc;
    expect_at(f + 10, "pre_run",   1'b0, 1'b1, 1'b0, 0);
    expect_at(f + 11, "first_run", 1'b0, 1'b0, 1'b1, 0);
    wait_to(f + 12);

    // Short lock loss in RUN.
    g = cyc;
    locked_i = 1'b0;
`ifdef PLL_SUPERVISOR_LOSS_FILTER_EN
    expect_at(g + 3, "glitch_filtered", 1'b0, 1'b0, 1'b1, 0);
    expect_at(g + 5, "glitch_held",     1'b0, 1'b0, 1'b1, 0);
    tick(1);
    locked_i = 1'b1;
    wait_to(g + 6);
    h = cyc;
    locked_i = 1'b0;
    expect_at(h + 4, "filter_pending", 1'b0, 1'b0, 1'b1, 0);
    expect_recover(h + 5, 1);
    tick(3);
    locked_i = 1'b1;
    wait_to(h + 19);
`else
    expect_at(g + 2, "pre_loss", 1'b0, 1'b0, 1'b1, 0);
    expect_recover(g + 3, 1);
    tick(1);
    locked_i = 1'b1;
    wait_to(g + 17);
`endif

    // Reset mid-RUN, then lock never arrives.
    t = cyc;
    rst      = 1'b1;
    locked_i = 1'b0;
    expect_at(t + 1, "rst_mid_run", 1'b1, 1'b1, 1'b0, 0);
    tick(3);
    rst = 1'b0;
    r   = cyc;
    expect_at(r + 3,  "nolock_rst0",   1'b1, 1'b1, 1'b0, 0);
    expect_at(r + 4,  "nolock_wait0",  1'b0, 1'b1, 1'b0, 0);
    expect_at(r + 23, "nolock_wend0",  1'b0, 1'b1, 1'b0, 0);
    expect_at(r + 24, "nolock_rst1",   1'b1, 1'b1, 1'b0, 0);
    expect_at(r + 27, "nolock_rst1e",  1'b1, 1'b1, 1'b0, 0);
    expect_at(r + 28, "nolock_wait1",  1'b0, 1'b1, 1'b0, 0);
    expect_at(r + 47, "nolock_wend1",  1'b0, 1'b1, 1'b0, 0);
    expect_at(r + 48, "nolock_rst2",   1'b1, 1'b1, 1'b0, 0);

    // Lock seen on the same cycle as the timeout: lock wins.
    w = r + 52;
    wait_to(w + 17);
    locked_i = 1'b1;
    s = w + 20;
    expect_at(s, "lock_wins", 1'b0, 1'b1, 1'b0, 0);

    // One low sample after 5 highs in STABLE restarts qualification.
    wait_to(s + 3);
    locked_i = 1'b0;
    expect_at(s + 8,  "stable_restart", 1'b0, 1'b1, 1'b0, 0);
    expect_at(s + 14, "stable_fresh7",  1'b0, 1'b1, 1'b0, 0);
    expect_at(s + 15, "stable_run",     1'b0, 1'b0, 1'b1, 0);
    tick(1);
    locked_i = 1'b1;
    wait_to(s + 16);

    // 300 lock losses: counter saturates at 255.
    for (int unsigned i = 0; i < 300; i++) begin
      t = cyc;
      c = (i + 1 > 255) ? 255 : i + 1;
      locked_i = 1'b0;
      expect_at(t + 25, "relock_sat", 1'b0, 1'b0, 1'b1, c);
      tick(3);
      locked_i = 1'b1;
      wait_to(t + 25);
    end

    tick(3);
    if (q_cyc.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL leftover_expectations count=%0d required=0", q_cyc.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
